instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 141 ++++++++++++++
 tb/tb_instr_fetch.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit.
//   Runs a four-state request engine (IDLE/REQ/WAIT/HOLD) against an
//   instruction memory with a ready/rvalid handshake. It presents one
//   registered instruction plus its PC to decode, and parks a second
//   returned word in a one-entry hold buffer while decode is stalled.
//   A redirect reloads the PC at any time. A response that is already
//   in flight when the redirect arrives is dropped via drop_pending.
// Ports:
//   clk, rst                  clock, async active-low reset
//   imem_req/imem_addr        fetch request to memory (addr = pc)
//   imem_ready                memory accepts request this cycle
//   imem_rvalid/imem_rdata    returned instruction word
//   stall                     downstream cannot consume this cycle
//   redirect_valid/_pc        branch/jump target
//   instr_reg_fetch/pc_fetch  registered instruction and its PC
//   fetch_valid               output valid, consumed on !stall
//   misalign_err              sticky: misaligned redirect target seen
module instr_fetch #(
  parameter int                    data_width = 32,
  parameter logic [data_width-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [data_width-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [data_width-1:0] imem_rdata,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [data_width-1:0] redirect_pc,
  output logic [data_width-1:0] instr_reg_fetch,
  output logic [data_width-1:0] pc_fetch,
  output logic                  fetch_valid,
  output logic                  misalign_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  localparam logic [data_width-1:0] PC_STEP = data_width'(4);

  state_t                state, state_n;
  logic [data_width-1:0] pc, pc_n;
  logic [data_width-1:0] instr_n, pcf_n;
  logic [data_width-1:0] hold_instr, hold_instr_n, hold_pc, hold_pc_n;
  logic                  fv_n, drop_pending, drop_n, misalign_n;
  logic                  accept, out_free;

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign accept    = imem_req & imem_ready;
  // Output register can take a new word this cycle if empty or being consumed.
  assign out_free  = !fetch_valid || !stall;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    instr_n      = instr_reg_fetch;
    pcf_n        = pc_fetch;
    fv_n         = fetch_valid;
    hold_instr_n = hold_instr;
    hold_pc_n    = hold_pc;
    drop_n       = drop_pending;
    misalign_n   = misalign_err | (redirect_valid & (|redirect_pc[1:0]));

    if (fetch_valid && !stall) fv_n = 1'b0;

    case (state)
      IDLE: state_n = REQ;
      REQ:  if (accept) state_n = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          if (drop_pending) begin
            drop_n  = 1'b0;
            state_n = REQ;
          end else if (out_free) begin
            instr_n = imem_rdata;
            pcf_n   = pc;
            fv_n    = 1'b1;
            pc_n    = pc + PC_STEP;
            state_n = REQ;
          end else begin
            hold_instr_n = imem_rdata;
            hold_pc_n    = pc;
            pc_n         = pc + PC_STEP;
            state_n      = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          instr_n = hold_instr;
          pcf_n   = hold_pc;
          fv_n    = 1'b1;
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase

    // Redirect overrides everything above. If a request is still in flight
    // (accepted now, or waiting without its data this cycle) its response
    // must be swallowed, so wait for it with drop_pending set.
    if (redirect_valid) begin
      pc_n    = {redirect_pc[data_width-1:2], 2'b00};
      instr_n = instr_reg_fetch;
      pcf_n   = pc_fetch;
      fv_n    = 1'b0;
      if ((state == REQ && accept) || (state == WAIT && !imem_rvalid)) begin
        drop_n  = 1'b1;
        state_n = WAIT;
      end else begin
        drop_n  = 1'b0;
        state_n = REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      instr_reg_fetch <= '0;
      pc_fetch        <= '0;
      fetch_valid     <= 1'b0;
      hold_instr      <= '0;
      hold_pc         <= '0;
      drop_pending    <= 1'b0;
      misalign_err    <= 1'b0;
    end else begin
      state           <= state_n;
      pc              <= pc_n;
      instr_reg_fetch <= instr_n;
      pc_fetch        <= pcf_n;
      fetch_valid     <= fv_n;
      hold_instr      <= hold_instr_n;
      hold_pc         <= hold_pc_n;
      drop_pending    <= drop_n;
      misalign_err    <= misalign_n;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch. Stimulus acts as the instruction
// memory and pushes every word it expects decode to see; a monitor pops
// and compares whenever an output word is consumed.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instr_reg_fetch, pc_fetch;
  logic        fetch_valid, misalign_err;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb[$];

  instr_fetch #(.data_width(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_reg_fetch(instr_reg_fetch), .pc_fetch(pc_fetch),
    .fetch_valid(fetch_valid), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h0) ? 32'h1234_5678 : (a ^ 32'h5A5A_5A5A);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a word is consumed on a cycle with fetch_valid & !stall.
  always @(negedge clk) begin
    if (rst && fetch_valid && !stall) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got pc %h instr %h expected none", pc_fetch, instr_reg_fetch);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("sb_pc", pc_fetch, e[63:32]);
        chk("sb_instr", instr_reg_fetch, e[31:0]);
      end
    end
  end

  task automatic wait_req(input string name);
    int n = 0;
    while (!imem_req && n < 20) begin
      cyc();
      n++;
    end
    chk(name, {31'b0, imem_req}, 32'd1);
  endtask

  // Memory side of one fetch: optional ready-low cycles, accept, data next cycle.
  task automatic do_fetch(input logic [31:0] a, input int delay);
    wait_req("req_timeout");
    chk("fetch_addr", imem_addr, a);
    for (int i = 0; i < delay; i++) begin
      cyc();
      chk("req_held", {31'b0, imem_req}, 32'd1);
      chk("addr_stable", imem_addr, a);
    end
    imem_ready = 1'b1;
    cyc();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = mem(a);
    sb.push_back({a, mem(a)});
    cyc();
    imem_rvalid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_fv"}, {31'b0, fetch_valid}, 32'd0);
    chk({tag, "_instr"}, instr_reg_fetch, 32'h0);
    chk({tag, "_pcf"}, pc_fetch, 32'h0);
    chk({tag, "_mis"}, {31'b0, misalign_err}, 32'd0);
  endtask

  initial begin
    #1;
    chk_reset("rst0");
    cyc(); cyc();
    rst = 1'b1;
    chk("rel_req", {31'b0, imem_req}, 32'd0);

    // First fetch with ready low 3 cycles, then back-to-back fetches.
    do_fetch(32'h0, 3);
    chk("first_fv", {31'b0, fetch_valid}, 32'd1);
    chk("first_instr", instr_reg_fetch, 32'h1234_5678);
    chk("first_pcf", pc_fetch, 32'h0);
    do_fetch(32'h4, 0);
    do_fetch(32'h8, 0);

    // Reset while a request is outstanding; rvalid during reset ignored.
    wait_req("rstw_req");
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk_reset("rstw");
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    cyc(); cyc();
    imem_rvalid = 1'b0;
    chk_reset("rstw2");
    rst = 1'b1;
    chk("rel2_req", {31'b0, imem_req}, 32'd0);

    // Stall with full output: second word goes to hold buffer.
    stall = 1'b1;
    do_fetch(32'h0, 0);
    do_fetch(32'h4, 0);
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    chk("hold_fv", {31'b0, fetch_valid}, 32'd1);
    chk("hold_pcf", pc_fetch, 32'h0);
    cyc();
    chk("hold_req2", {31'b0, imem_req}, 32'd0);
    chk("hold_pcf2", pc_fetch, 32'h0);
    chk("hold_instr2", instr_reg_fetch, 32'h1234_5678);
    stall = 1'b0;
    cyc();
    chk("unhold_fv", {31'b0, fetch_valid}, 32'd1);
    chk("unhold_pcf", pc_fetch, 32'h4);
    do_fetch(32'h8, 0);

    // Redirect while waiting: in-flight data dropped, refetch at 0x100.
    wait_req("rdw_req");
    chk("rdw_addr", imem_addr, 32'hC);
    imem_ready = 1'b1;
    cyc();
    imem_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cyc();
    redirect_valid = 1'b0;
    chk("rdw_req0", {31'b0, imem_req}, 32'd0);
    chk("rdw_fv0", {31'b0, fetch_valid}, 32'd0);
    cyc();
    chk("rdw_req1", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = mem(32'hC);
    cyc();
    imem_rvalid = 1'b0;
    chk("rdw_fv1", {31'b0, fetch_valid}, 32'd0);
    chk("rdw_req2", {31'b0, imem_req}, 32'd1);
    do_fetch(32'h100, 0);

    // Misaligned redirect in REQ without accept: sticky flag, aligned fetch.
    chk("mis_pre", {31'b0, misalign_err}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    cyc();
    redirect_valid = 1'b0;
    chk("mis_set", {31'b0, misalign_err}, 32'd1);
    chk("mis_addr", imem_addr, 32'h100);
    do_fetch(32'h100, 0);

    // Aligned redirect near the top of memory, then PC wrap to 0.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    chk("mis_sticky", {31'b0, misalign_err}, 32'd1);
    do_fetch(32'hFFFF_FFFC, 0);
    do_fetch(32'h0, 0);

    // Redirect coinciding with rvalid: data discarded, no drop wait.
    wait_req("rdv_req");
    chk("rdv_addr", imem_addr, 32'h4);
    imem_ready = 1'b1;
    cyc();
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = mem(32'h4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cyc();
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    chk("rdv_fv", {31'b0, fetch_valid}, 32'd0);
    chk("rdv_req", {31'b0, imem_req}, 32'd1);
    chk("rdv_addr2", imem_addr, 32'h200);
    do_fetch(32'h200, 0);

    cyc(); cyc(); cyc();
    chk("sb_empty", sb.size(), 32'd0);
    chk("end_mis", {31'b0, misalign_err}, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
